// File: rtl/fifo_byte_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_byte_reader
//  Purpose  : Drains a 32-bit word FIFO and serialises each word into four
//             bytes on a valid/ready stream, with a one-word prefetch slot.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_byte_reader #(
    parameter bit MSB_FIRST   = 1'b0,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   enable_in,
    input  logic                   fifo_empty_in,
    input  logic [31:0]            fifo_data_in,
    input  logic                   fifo_valid_in,
    output logic                   fifo_deq_out,
    output logic [7:0]             data_out,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic [COUNT_WIDTH-1:0] word_count_out,
    output logic                   protocol_err_out
);

    localparam logic [1:0] C_LAST_IDX = 2'd3;

    // Registered state
    logic [31:0]            r_cur_word;
    logic                   r_cur_valid;
    logic [1:0]             r_cur_idx;
    logic [31:0]            r_pend_word;
    logic                   r_pend_valid;
    logic                   r_outstanding;
    logic [COUNT_WIDTH-1:0] r_word_count;
    logic                   r_protocol_err;

    // Next-state values
    logic [31:0]            w_cur_word_nxt;
    logic                   w_cur_valid_nxt;
    logic [1:0]             w_cur_idx_nxt;
    logic [31:0]            w_pend_word_nxt;
    logic                   w_pend_valid_nxt;
    logic                   w_outstanding_nxt;
    logic [COUNT_WIDTH-1:0] w_word_count_nxt;
    logic                   w_protocol_err_nxt;

    logic                   w_deq;
    logic                   w_hs;
    logic                   w_last_hs;
    logic                   w_capture;
    logic [1:0]             w_lane;

    // Gating with the reset input keeps the request low while the block is held in reset.
    assign w_deq     = rst_n_in && enable_in && !fifo_empty_in && !r_outstanding && !r_pend_valid;
    assign w_hs      = r_cur_valid && ready_in;
    assign w_last_hs = w_hs && (r_cur_idx == C_LAST_IDX);
    assign w_capture = fifo_valid_in && r_outstanding;

    always_comb begin
        w_cur_word_nxt     = r_cur_word;
        w_cur_valid_nxt    = r_cur_valid;
        w_cur_idx_nxt      = r_cur_idx;
        w_pend_word_nxt    = r_pend_word;
        w_pend_valid_nxt   = r_pend_valid;
        w_word_count_nxt   = r_word_count;
        w_outstanding_nxt  = w_deq;
        w_protocol_err_nxt = r_protocol_err
                             || (fifo_valid_in && !r_outstanding)
                             || (r_outstanding && !fifo_valid_in);

        if (w_last_hs) begin
            w_word_count_nxt = r_word_count + COUNT_WIDTH'(1);
            w_cur_idx_nxt    = 2'd0;
            if (r_pend_valid) begin
                // The prefetched word is older than anything arriving now.
                w_cur_word_nxt   = r_pend_word;
                w_cur_valid_nxt  = 1'b1;
                w_pend_valid_nxt = 1'b0;
                if (w_capture) begin
                    w_pend_word_nxt  = fifo_data_in;
                    w_pend_valid_nxt = 1'b1;
                end
            end else if (w_capture) begin
                w_cur_word_nxt  = fifo_data_in;
                w_cur_valid_nxt = 1'b1;
            end else begin
                w_cur_valid_nxt = 1'b0;
            end
        end else begin
            if (w_hs) begin
                w_cur_idx_nxt = r_cur_idx + 2'd1;
            end
            if (w_capture) begin
                if (!r_cur_valid) begin
                    w_cur_word_nxt  = fifo_data_in;
                    w_cur_valid_nxt = 1'b1;
                    w_cur_idx_nxt   = 2'd0;
                end else begin
                    w_pend_word_nxt  = fifo_data_in;
                    w_pend_valid_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_cur_word     <= 32'd0;
            r_cur_valid    <= 1'b0;
            r_cur_idx      <= 2'd0;
            r_pend_word    <= 32'd0;
            r_pend_valid   <= 1'b0;
            r_outstanding  <= 1'b0;
            r_word_count   <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            r_cur_word     <= w_cur_word_nxt;
            r_cur_valid    <= w_cur_valid_nxt;
            r_cur_idx      <= w_cur_idx_nxt;
            r_pend_word    <= w_pend_word_nxt;
            r_pend_valid   <= w_pend_valid_nxt;
            r_outstanding  <= w_outstanding_nxt;
            r_word_count   <= w_word_count_nxt;
            r_protocol_err <= w_protocol_err_nxt;
        end
    end

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_lane = C_LAST_IDX - r_cur_idx;
        end else begin : g_lsb_first
            assign w_lane = r_cur_idx;
        end
    endgenerate

    always_comb begin
        data_out = 8'h00;
        if (r_cur_valid) begin
            case (w_lane)
                2'd0:    data_out = r_cur_word[7:0];
                2'd1:    data_out = r_cur_word[15:8];
                2'd2:    data_out = r_cur_word[23:16];
                default: data_out = r_cur_word[31:24];
            endcase
        end
    end

    assign fifo_deq_out     = w_deq;
    assign valid_out        = r_cur_valid;
    assign word_count_out   = r_word_count;
    assign protocol_err_out = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_byte_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_byte_reader
//  Purpose  : Directed self-checking bench for fifo_byte_reader (both byte orders).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_byte_reader;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        enable_in;
    logic        ready_in;
    logic        spur_valid;
    logic        model_valid;
    logic [31:0] fifo_data_in;
    logic        fifo_valid_in;
    logic        fifo_empty_in;

    logic [31:0] mem [16];
    logic [3:0]  wr_ptr;
    logic [3:0]  rd_ptr;
    int          deq_pulses;

    logic        deq_l, deq_m, valid_l, valid_m, err_l, err_m;
    logic [7:0]  data_l, data_m;
    logic [15:0] cnt_l, cnt_m;

    int n_pass  = 0;
    int n_total = 0;

    assign fifo_valid_in = model_valid | spur_valid;
    assign fifo_empty_in = (wr_ptr == rd_ptr);

    always #5 clk_in = ~clk_in;

    fifo_byte_reader #(.MSB_FIRST(1'b0), .COUNT_WIDTH(16)) dut_lsb (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .enable_in(enable_in),
        .fifo_empty_in(fifo_empty_in), .fifo_data_in(fifo_data_in),
        .fifo_valid_in(fifo_valid_in), .fifo_deq_out(deq_l),
        .data_out(data_l), .valid_out(valid_l), .ready_in(ready_in),
        .word_count_out(cnt_l), .protocol_err_out(err_l)
    );

    fifo_byte_reader #(.MSB_FIRST(1'b1), .COUNT_WIDTH(16)) dut_msb (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .enable_in(enable_in),
        .fifo_empty_in(fifo_empty_in), .fifo_data_in(fifo_data_in),
        .fifo_valid_in(fifo_valid_in), .fifo_deq_out(deq_m),
        .data_out(data_m), .valid_out(valid_m), .ready_in(ready_in),
        .word_count_out(cnt_m), .protocol_err_out(err_m)
    );

    // FIFO read port model: data valid the cycle after an accepted dequeue.
    initial begin
        logic d;
        rd_ptr       = 4'd0;
        model_valid  = 1'b0;
        fifo_data_in = 32'd0;
        deq_pulses   = 0;
        forever begin
            @(negedge clk_in);
            #2;
            d = deq_l;
            @(posedge clk_in);
            #1;
            if (d) begin
                fifo_data_in = mem[rd_ptr];
                rd_ptr       = rd_ptr + 4'd1;
                deq_pulses   = deq_pulses + 1;
                model_valid  = 1'b1;
            end else begin
                model_valid  = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 4'd1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!valid_l && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        chk(tag, {31'd0, valid_l}, 32'd1);
    endtask

    // Checks the LSB-first byte at this negedge, then moves to the next one.
    task automatic expect_byte(input string tag, input logic [7:0] exp);
        chk(tag, {23'd0, valid_l, data_l}, {23'd0, 1'b1, exp});
        @(negedge clk_in);
    endtask

    initial begin
        int base;
        wr_ptr     = 4'd0;
        rst_n_in   = 1'b0;
        enable_in  = 1'b0;
        ready_in   = 1'b1;
        spur_valid = 1'b0;
        repeat (3) @(negedge clk_in);

        // Reset state
        chk("rst_deq",   {31'd0, deq_l},   32'd0);
        chk("rst_valid", {31'd0, valid_l}, 32'd0);
        chk("rst_data",  {24'd0, data_l},  32'd0);
        chk("rst_count", {16'd0, cnt_l},   32'd0);
        chk("rst_err",   {31'd0, err_l},   32'd0);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        // Single word: latency and byte order for both instances
        push(32'hA1B2C3D4);
        enable_in = 1'b1;
        #1;
        chk("t1_deq_lsb", {31'd0, deq_l}, 32'd1);
        chk("t1_deq_msb", {31'd0, deq_m}, 32'd1);
        @(negedge clk_in);
        chk("t1_valid_t1", {31'd0, valid_l}, 32'd0);
        @(negedge clk_in);
        chk("t1_msb_b0", {24'd0, data_m}, 32'hA1);
        expect_byte("t1_b0", 8'hD4);
        chk("t1_msb_b1", {24'd0, data_m}, 32'hB2);
        expect_byte("t1_b1", 8'hC3);
        chk("t1_msb_b2", {24'd0, data_m}, 32'hC3);
        expect_byte("t1_b2", 8'hB2);
        chk("t1_msb_b3", {24'd0, data_m}, 32'hD4);
        expect_byte("t1_b3", 8'hA1);
        chk("t1_valid_end", {31'd0, valid_l}, 32'd0);
        chk("t1_data_end",  {24'd0, data_l},  32'd0);
        chk("t1_count",     {16'd0, cnt_l},   32'd1);
        chk("t1_count_msb", {16'd0, cnt_m},   32'd1);
        chk("t1_deqs",      deq_pulses,       32'd1);

        // Back-to-back words: 12 bytes with no bubbles
        base = deq_pulses;
        push(32'h03020100);
        push(32'h07060504);
        push(32'h0B0A0908);
        wait_valid("t2_start");
        for (int i = 0; i < 12; i++) begin
            expect_byte($sformatf("t2_b%0d", i), 8'(i));
        end
        chk("t2_valid_end", {31'd0, valid_l}, 32'd0);
        chk("t2_count",     {16'd0, cnt_l},   32'd4);
        chk("t2_deqs",      deq_pulses - base, 32'd3);

        // Backpressure mid-word
        base = deq_pulses;
        push(32'h13121110);
        push(32'h17161514);
        wait_valid("t3_start");
        expect_byte("t3_b0", 8'h10);
        ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_byte($sformatf("t3_hold%0d", i), 8'h11);
        end
        chk("t3_deqs_held", deq_pulses - base, 32'd2);
        ready_in = 1'b1;
        for (int i = 1; i < 8; i++) begin
            expect_byte($sformatf("t3_b%0d", i), 8'(8'h10 + i));
        end
        chk("t3_valid_end", {31'd0, valid_l}, 32'd0);
        chk("t3_count",     {16'd0, cnt_l},   32'd6);

        // Empty FIFO, then enable low with data waiting
        base = deq_pulses;
        repeat (3) @(negedge clk_in);
        chk("t4_empty_deq", {31'd0, deq_l}, 32'd0);
        enable_in = 1'b0;
        push(32'h23222120);
        repeat (4) @(negedge clk_in);
        chk("t4_dis_deq",   {31'd0, deq_l},    32'd0);
        chk("t4_dis_valid", {31'd0, valid_l},  32'd0);
        chk("t4_dis_pulses", deq_pulses - base, 32'd0);
        chk("t4_err_clean", {31'd0, err_l},    32'd0);

        // Unrequested FIFO valid: data discarded, sticky error
        fifo_data_in = 32'hDEADBEEF;
        spur_valid   = 1'b1;
        @(negedge clk_in);
        spur_valid   = 1'b0;
        @(negedge clk_in);
        chk("t5_err",       {31'd0, err_l},   32'd1);
        chk("t5_err_msb",   {31'd0, err_m},   32'd1);
        chk("t5_discarded", {31'd0, valid_l}, 32'd0);
        repeat (3) @(negedge clk_in);
        chk("t5_err_sticky", {31'd0, err_l},  32'd1);

        // Async reset while byte 2 is pending
        enable_in = 1'b1;
        wait_valid("t6_start");
        expect_byte("t6_b0", 8'h20);
        expect_byte("t6_b1", 8'h21);
        chk("t6_b2", {24'd0, data_l}, 32'h22);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, valid_l}, 32'd0);
        chk("t6_rst_data",  {24'd0, data_l},  32'd0);
        chk("t6_rst_count", {16'd0, cnt_l},   32'd0);
        chk("t6_rst_err",   {31'd0, err_l},   32'd0);
        chk("t6_rst_deq",   {31'd0, deq_l},   32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        push(32'hDDCCBBAA);
        wait_valid("t7_start");
        chk("t7_count0", {16'd0, cnt_l},  32'd0);
        chk("t7_msb_b0", {24'd0, data_m}, 32'hDD);
        expect_byte("t7_b0", 8'hAA);
        expect_byte("t7_b1", 8'hBB);
        expect_byte("t7_b2", 8'hCC);
        expect_byte("t7_b3", 8'hDD);
        chk("t7_count", {16'd0, cnt_l}, 32'd1);
        chk("t7_err",   {31'd0, err_l}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_byte_reader.md
# fifo_byte_reader

Read-side drain for the design's 32-bit word FIFOs: issues dequeue requests, captures the words the FIFO returns one cycle later, and serialises each word into four bytes on a valid/ready byte stream. It sits between a FIFO's `deq`/`data_out`/`valid_out`/`empty` port and a byte-wide consumer such as a UART TX or packet framer. A one-word prefetch slot sustains one byte per cycle under continuous `ready_in`.

## Interface
Parameters:
- `MSB_FIRST`, default 0: 0 sends byte[7:0] first; 1 sends byte[31:24] first.
- `COUNT_WIDTH`, default 16: width of `word_count_out`.

Ports:
- `clk_in`  input  1  sole clock, rising edge.
- `rst_n_in`  input  1  reset, asynchronous assert, active-low; all state clears while low.
- `enable_in`  input  1  permits new dequeues; words already requested or held still drain.
- `fifo_empty_in`  input  1  FIFO empty flag.
- `fifo_data_in`  input  32  FIFO read data.
- `fifo_valid_in`  input  1  FIFO read-data valid, one cycle after an accepted dequeue.
- `fifo_deq_out`  output  1  dequeue request to FIFO.
- `data_out`  output  8  current byte.
- `valid_out`  output  1  `data_out` is valid.
- `ready_in`  input  1  consumer accepts the byte when `valid_out && ready_in`.
- `word_count_out`  output  COUNT_WIDTH  count of fully sent words; wraps modulo 2^COUNT_WIDTH.
- `protocol_err_out`  output  1  sticky: FIFO handshake violated.

## Operation
- State: `cur` (word, valid bit, 2-bit byte index), `pend` (word, valid bit), `outstanding` (1 bit).
- `fifo_deq_out` = `enable_in && !fifo_empty_in && !outstanding && !pend_valid`. It is combinational from registered state and inputs.
- On a clock edge where `fifo_deq_out` is high, set `outstanding`. On the next edge, clear `outstanding` unconditionally.
- Word capture happens on an edge where `fifo_valid_in` is high and `outstanding` is set:
  - If `cur` is empty, or `cur` is completing its last byte on this same edge, load `cur`, byte index 0.
  - Otherwise, load `pend`.
- A byte handshake (`valid_out && ready_in`) advances the byte index.
- On the handshake for index 3:
  - Increment `word_count_out`.
  - Move `pend` into `cur` if `pend` is valid, with index 0. The incoming word takes priority only when `pend` is empty. Otherwise `cur` becomes empty.
- `valid_out` = `cur_valid`.
- `data_out` selects the byte by index and `MSB_FIRST`. It is 0 when `cur` is empty.
- Bytes hold stable while `valid_out && !ready_in`.
- `protocol_err_out` sets on either violation below and stays set until reset:
  - `fifo_valid_in` high with `outstanding` clear; that data is discarded.
  - `outstanding` set but `fifo_valid_in` low.
- `enable_in` low blocks only new `fifo_deq_out`. An outstanding word is still captured and sent.

## Timing
- Reset values: `fifo_deq_out` 0, `data_out` 0x00, `valid_out` 0, `word_count_out` 0, `protocol_err_out` 0.
  - Internal state also clears: `cur`, `pend` and `outstanding` all empty/0.
- Latency, `fifo_empty_in` falling to first byte:
  - Cycle t: `fifo_deq_out` high.
  - Cycle t+1: FIFO data valid.
  - Cycle t+2: `valid_out` high.
- Throughput under continuous `ready_in` and non-empty FIFO: one byte per cycle, no bubbles between words.
  - The next dequeue issues the cycle after `pend` frees.
- Simultaneous arrival and last-byte handshake with `pend` empty: the new word goes directly to `cur`, with no gap cycle.
- Reset asserted mid-word or with a dequeue in flight: all state drops immediately.
  - A FIFO `valid` seen after reset release with `outstanding` clear flags `protocol_err_out`. The integrator must reset the FIFO together with this block.
- `word_count_out` updates on the edge of the 4th byte handshake and is visible the next cycle.

## Test plan
- Single word, LSB first: FIFO holds 0xA1B2C3D4, `ready_in`=1 → bytes D4, C3, B2, A1 on 4 consecutive cycles starting 2 cycles after the dequeue; `word_count_out`=1.
- `MSB_FIRST`=1, same word → A1, B2, C3, D4.
- Back-to-back: FIFO holds 0x03020100, 0x07060504, 0x0B0A0908, `ready_in`=1 → 12 consecutive valid cycles carrying 00..0B, exactly 3 `fifo_deq_out` pulses, `word_count_out`=3.
- Backpressure: `ready_in` low for 5 cycles mid-word → `data_out` held, byte index frozen, at most one further dequeue issued (into `pend`), no data lost.
- Empty FIFO / `enable_in`=0 → `fifo_deq_out` never asserts, `valid_out` 0.
  - Pulsing `fifo_valid_in` with no request → `protocol_err_out`=1 and stays 1.
- Async reset: drop `rst_n_in` between an edge and the next while byte 2 of a word is pending → all outputs 0 immediately, without waiting for a clock edge. After release, normal operation resumes from `word_count_out`=0.
